// File: rtl/msp430_wakeup_ctrl_if.sv
// Wakeup controller bus: raw events, per-channel controls and the pending/overflow view.
interface msp430_wakeup_ctrl_if #(
    parameter int NCH = 8
);
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   wkup_in;
    logic [NCH-1:0]   wkup_en;
    logic [2*NCH-1:0] wkup_edge;
    logic [NCH-1:0]   wkup_clr;
    logic [NCH-1:0]   wkup_pend;
    logic [NCH-1:0]   wkup_ovf;
    logic             wkup_out;
    logic [IDW-1:0]   wkup_id;

    modport master (
        output wkup_in, wkup_en, wkup_edge, wkup_clr,
        input  wkup_pend, wkup_ovf, wkup_out, wkup_id
    );

    modport slave (
        input  wkup_in, wkup_en, wkup_edge, wkup_clr,
        output wkup_pend, wkup_ovf, wkup_out, wkup_id
    );
endinterface

// File: rtl/msp430_wakeup_ctrl.sv
// Multi-channel wakeup event controller: per-channel sync, glitch filter,
// edge-qualified sticky pending/overflow flags, and a prioritised wakeup id.
module msp430_wakeup_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 0
) (
    input  logic       mclk,
    input  logic       puc_rst,
    input  logic       wkup_in,
    input  logic       wkup_en,
    input  logic [1:0] wkup_mode,
    input  logic       wkup_clr,
    output logic       wkup_pend,
    output logic       wkup_ovf
);
    localparam logic [3:0] CNT_MAX = 4'(FILT_CYC);

    logic       s;
    logic       filt;
    logic [3:0] cnt;
    logic       chg;
    logic       ev;
    logic       ev_en;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = wkup_in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge mclk) begin
            if (puc_rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= wkup_in;
                for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
            end
        end
        assign s = sync_q[SYNC_STAGES-1];
    end

    // filt flips on the sample that completes FILT_CYC+1 consecutive mismatches
    assign chg   = (s != filt) && (cnt == CNT_MAX);
    assign ev    = chg && (s ? wkup_mode[0] : wkup_mode[1]);
    assign ev_en = ev && wkup_en;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (s == filt) begin
            cnt  <= '0;
        end else if (chg) begin
            filt <= s;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 4'd1;
        end
    end

    // a clear coinciding with a fresh event leaves the event pending, not overflowed
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            wkup_pend <= 1'b0;
            wkup_ovf  <= 1'b0;
        end else if (wkup_clr) begin
            wkup_pend <= ev_en;
            wkup_ovf  <= 1'b0;
        end else if (ev_en) begin
            wkup_pend <= 1'b1;
            if (wkup_pend) wkup_ovf <= 1'b1;
        end
    end
endmodule

module msp430_wakeup_ctrl #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 0
) (
    input  logic                 mclk,
    input  logic                 puc_rst,
    msp430_wakeup_ctrl_if.slave  bus
);
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] pend;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] act;
    logic [IDW-1:0] id;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        msp430_wakeup_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC)
        ) u_chan (
            .mclk      (mclk),
            .puc_rst   (puc_rst),
            .wkup_in   (bus.wkup_in[i]),
            .wkup_en   (bus.wkup_en[i]),
            .wkup_mode (bus.wkup_edge[2*i +: 2]),
            .wkup_clr  (bus.wkup_clr[i]),
            .wkup_pend (pend[i]),
            .wkup_ovf  (ovf[i])
        );
    end

    // masking only hides pending channels; it never clears them
    assign act = pend & bus.wkup_en;

    always_comb begin
        id = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (act[i]) id = IDW'(i);
        end
    end

    assign bus.wkup_pend = pend;
    assign bus.wkup_ovf  = ovf;
    assign bus.wkup_out  = |act;
    assign bus.wkup_id   = id;
endmodule

// File: tb/tb_msp430_wakeup_ctrl.sv
// Random + directed bench for msp430_wakeup_ctrl: two filter settings checked
// every cycle against a sample-history reference model, plus literal pins.
module tb_msp430_wakeup_ctrl;
    localparam int NCH = 8;
    localparam int S   = 2;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [7:0]  in_v, en_v, clr_v;
    logic [15:0] edge_v;

    int n_chk = 0;
    int n_err = 0;
    int n_prt = 0;

    always #5 mclk = ~mclk;

    msp430_wakeup_ctrl_if #(.NCH(NCH)) bus0 ();
    msp430_wakeup_ctrl_if #(.NCH(NCH)) bus3 ();

    assign bus0.wkup_in = in_v;  assign bus0.wkup_en = en_v;
    assign bus0.wkup_edge = edge_v; assign bus0.wkup_clr = clr_v;
    assign bus3.wkup_in = in_v;  assign bus3.wkup_en = en_v;
    assign bus3.wkup_edge = edge_v; assign bus3.wkup_clr = clr_v;

    msp430_wakeup_ctrl #(.NCH(NCH), .SYNC_STAGES(S), .FILT_CYC(0)) dut0 (
        .mclk(mclk), .puc_rst(puc_rst), .bus(bus0));
    msp430_wakeup_ctrl #(.NCH(NCH), .SYNC_STAGES(S), .FILT_CYC(3)) dut3 (
        .mclk(mclk), .puc_rst(puc_rst), .bus(bus3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_prt < 40) begin
                n_prt++;
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] syn_m [S];
    logic [7:0] filt_m [2];
    logic [7:0] pend_m [2];
    logic [7:0] ovf_m  [2];
    int         hist   [2][NCH][16];
    int         fc     [2];

    function automatic int exp_id(input logic [7:0] p, input logic [7:0] e);
        for (int i = 0; i < NCH; i++) if (p[i] && e[i]) return i;
        return 0;
    endfunction

    initial begin
        fc[0] = 0; fc[1] = 3;
        for (int d = 0; d < 2; d++) begin
            filt_m[d] = '0; pend_m[d] = '0; ovf_m[d] = '0;
            for (int i = 0; i < NCH; i++) for (int j = 0; j < 16; j++) hist[d][i][j] = -1;
        end
        for (int k = 0; k < S; k++) syn_m[k] = '0;
    end

    always @(posedge mclk) begin
        logic [7:0] s;
        logic       stable, chg, ev, evq;
        logic [1:0] mode;
        s = syn_m[S-1];
        if (puc_rst) begin
            for (int d = 0; d < 2; d++) begin
                filt_m[d] = '0; pend_m[d] = '0; ovf_m[d] = '0;
                for (int i = 0; i < NCH; i++) for (int j = 0; j < 16; j++) hist[d][i][j] = -1;
            end
            for (int k = 0; k < S; k++) syn_m[k] = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NCH; i++) begin
                    for (int j = 15; j > 0; j--) hist[d][i][j] = hist[d][i][j-1];
                    hist[d][i][0] = int'(s[i]);
                    // level accepted once the last FILT+1 samples agree and differ from filt
                    stable = 1'b1;
                    for (int j = 0; j <= fc[d]; j++) if (hist[d][i][j] != int'(s[i])) stable = 1'b0;
                    chg  = stable && (s[i] != filt_m[d][i]);
                    mode = edge_v[2*i +: 2];
                    ev   = chg && (s[i] ? (mode == 2'b01 || mode == 2'b11)
                                        : (mode == 2'b10 || mode == 2'b11));
                    if (chg) filt_m[d][i] = s[i];
                    evq = ev && en_v[i];
                    if (clr_v[i] && !evq)      begin pend_m[d][i] = 1'b0; ovf_m[d][i] = 1'b0; end
                    else if (clr_v[i] && evq)  begin pend_m[d][i] = 1'b1; ovf_m[d][i] = 1'b0; end
                    else if (evq && pend_m[d][i]) ovf_m[d][i] = 1'b1;
                    else if (evq)              pend_m[d][i] = 1'b1;
                end
            end
            for (int k = S - 1; k > 0; k--) syn_m[k] = syn_m[k-1];
            syn_m[0] = in_v;
        end
    end

    // per-cycle compare, shortly after every active edge
    always @(posedge mclk) begin
        #1;
        chk("d0_pend", 32'(bus0.wkup_pend), 32'(pend_m[0]));
        chk("d0_ovf",  32'(bus0.wkup_ovf),  32'(ovf_m[0]));
        chk("d0_out",  32'(bus0.wkup_out),  32'(|(pend_m[0] & en_v)));
        chk("d0_id",   32'(bus0.wkup_id),   32'(exp_id(pend_m[0], en_v)));
        chk("d3_pend", 32'(bus3.wkup_pend), 32'(pend_m[1]));
        chk("d3_ovf",  32'(bus3.wkup_ovf),  32'(ovf_m[1]));
        chk("d3_out",  32'(bus3.wkup_out),  32'(|(pend_m[1] & en_v)));
        chk("d3_id",   32'(bus3.wkup_id),   32'(exp_id(pend_m[1], en_v)));
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic clr_pulse(input logic [7:0] m);
        clr_v = m;
        @(negedge mclk);
        clr_v = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        puc_rst = 1'b1; in_v = '0; en_v = 8'hFF; clr_v = '0; edge_v = 16'h5555;
        wait_n(3);
        puc_rst = 1'b0;
        chk("rst_pend", 32'(bus0.wkup_pend), 32'h0);
        chk("rst_out",  32'(bus0.wkup_out),  32'h0);
        chk("rst_id",   32'(bus3.wkup_id),   32'h0);
        wait_n(2);

        // ch3 rise: pending two edges after the first sampling edge
        in_v[3] = 1'b1;
        @(posedge mclk); @(posedge mclk); #1;
        chk("t1_pend_k1", 32'(bus0.wkup_pend[3]), 32'h0);
        @(posedge mclk); #1;
        chk("t1_pend_k2", 32'(bus0.wkup_pend[3]), 32'h1);
        chk("t1_out",     32'(bus0.wkup_out),     32'h1);
        chk("t1_id",      32'(bus0.wkup_id),      32'h3);
        wait_n(6);
        clr_pulse(8'hFF);

        // ch0 both edges, filter 3: short pulse rejected
        edge_v[1:0] = 2'b11;
        in_v[0] = 1'b1; wait_n(3); in_v[0] = 1'b0;
        wait_n(8);
        chk("t2_short", 32'(bus3.wkup_pend[0]), 32'h0);
        clr_pulse(8'hFF);
        in_v[0] = 1'b1;
        repeat (5) @(posedge mclk); #1;
        chk("t2_lat_k4", 32'(bus3.wkup_pend[0]), 32'h0);
        @(posedge mclk); #1;
        chk("t2_lat_k5", 32'(bus3.wkup_pend[0]), 32'h1);
        wait_n(4);
        clr_pulse(8'h01);
        in_v[0] = 1'b0;
        wait_n(8);
        chk("t2_fall", 32'(bus3.wkup_pend[0]), 32'h1);

        // ch5 overflow then clear
        in_v[5] = 1'b1; wait_n(8);
        chk("t3_pend", 32'(bus0.wkup_pend[5]), 32'h1);
        in_v[5] = 1'b0; wait_n(8);
        in_v[5] = 1'b1; wait_n(8);
        chk("t3_ovf", 32'(bus0.wkup_ovf[5]), 32'h1);
        clr_pulse(8'h20);
        chk("t3_clr_pend", 32'(bus0.wkup_pend[5]), 32'h0);
        chk("t3_clr_ovf",  32'(bus0.wkup_ovf[5]),  32'h0);

        // ch2: clear on the same edge as a new event
        in_v[2] = 1'b1; wait_n(8);
        in_v[2] = 1'b0; wait_n(8);
        in_v[2] = 1'b1;
        @(negedge mclk); @(negedge mclk);
        clr_v[2] = 1'b1;
        @(posedge mclk); #1;
        chk("t4_pend", 32'(bus0.wkup_pend[2]), 32'h1);
        chk("t4_ovf",  32'(bus0.wkup_ovf[2]),  32'h0);
        @(negedge mclk); clr_v = '0;

        // masking and id priority
        edge_v = 16'h5555; in_v = '0; wait_n(8);
        clr_pulse(8'hFF);
        in_v = 8'h42; wait_n(8);
        en_v = 8'h42; #1;
        chk("t5_id1", 32'(bus0.wkup_id), 32'h1);
        @(negedge mclk); en_v = 8'h40; #1;
        chk("t5_id6", 32'(bus0.wkup_id), 32'h6);
        @(negedge mclk); en_v = 8'h00; #1;
        chk("t5_out",  32'(bus0.wkup_out),  32'h0);
        chk("t5_pend", 32'(bus0.wkup_pend), 32'h42);

        // reset mid-filter with everything pending, input held high across release
        @(negedge mclk); en_v = 8'hFF; in_v = '0; wait_n(8);
        clr_pulse(8'hFF);
        in_v = 8'hFF; wait_n(8);
        chk("t6_allpend", 32'(bus3.wkup_pend), 32'hFF);
        in_v = '0; wait_n(4);
        puc_rst = 1'b1; in_v = 8'hFF;
        @(posedge mclk); #1;
        chk("t6_rst_pend", 32'({bus0.wkup_pend, bus3.wkup_pend}), 32'h0);
        chk("t6_rst_ovf",  32'({bus0.wkup_ovf, bus3.wkup_ovf}),   32'h0);
        chk("t6_rst_out",  32'({bus0.wkup_out, bus3.wkup_out}),   32'h0);
        @(negedge mclk); puc_rst = 1'b0;
        @(posedge mclk); @(posedge mclk); #1;
        chk("t6_rel_k1", 32'(bus0.wkup_pend), 32'h0);
        @(posedge mclk); #1;
        chk("t6_rel_k2", 32'(bus0.wkup_pend), 32'hFF);
        chk("t6_rel_out", 32'(bus0.wkup_out), 32'h1);

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            @(negedge mclk);
            in_v  = in_v ^ 8'($urandom & $urandom);
            clr_v = 8'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) en_v = 8'($urandom);
            if ($urandom_range(0, 31) == 0) edge_v = 16'($urandom);
            puc_rst = ($urandom_range(0, 499) == 0);
        end
        @(negedge mclk); puc_rst = 1'b0; clr_v = '0;
        wait_n(3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
